// File: rtl/square_renderer_if.sv
// Pixel-plot request/response bundle between a square_renderer and its client.
// The renderer takes the slave side; the requester (or bench) takes the master side.
interface square_renderer_if;
  logic       go;
  logic       erase;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output go, erase, x_in, y_in, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  go, erase, x_in, y_in, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/square_renderer.sv
// Renders a SIZE x SIZE square one pixel per cycle, row-major, into a VGA adapter.
// Define SQUARE_RENDERER_CLIP_EN to suppress plot strobes for off-screen pixels.
module square_renderer #(
  parameter int SIZE  = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic              clock,
  input  logic              resetn,
  square_renderer_if.slave  bus
);

`ifdef SQUARE_RENDERER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic [3:0] LAST = 4'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cx, cy;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [2:0] col;
  logic [7:0] x_hold;
  logic [6:0] y_hold;
  logic [2:0] c_hold;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       last_col, last_pix, start;

  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
    return (sx <= 9'(X_MAX)) && (sy <= 8'(Y_MAX));
  endfunction

  // Sums are one bit wider than the outputs so the bounds test sees true positions
  assign sum_x    = {1'b0, x0} + {5'b0, cx};
  assign sum_y    = {1'b0, y0} + {4'b0, cy};
  assign last_col = (cx == LAST);
  assign last_pix = last_col && (cy == LAST);
  assign start    = (state == IDLE) && bus.go;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.go) state_nxt = DRAW;
      DRAW:    if (last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx     <= '0;
      cy     <= '0;
      x_hold <= '0;
      y_hold <= '0;
      c_hold <= '0;
    end else if (start) begin
      cx <= '0;
      cy <= '0;
    end else if (state == DRAW) begin
      x_hold <= sum_x[7:0];
      y_hold <= sum_y[6:0];
      c_hold <= col;
      if (last_pix) begin
        cx <= '0;
        cy <= '0;
      end else if (last_col) begin
        cx <= '0;
        cy <= cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end

  // Request fields are only captured on acceptance; a go while busy leaves them untouched
  always_ff @(posedge clock) begin
    if (start) begin
      x0  <= bus.x_in;
      y0  <= bus.y_in;
      col <= bus.erase ? 3'b000 : bus.colour_in;
    end
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    bus.plot   = 1'b0;
    bus.x      = x_hold;
    bus.y      = y_hold;
    bus.colour = c_hold;
    if (state == DRAW) begin
      bus.x      = sum_x[7:0];
      bus.y      = sum_y[6:0];
      bus.colour = col;
      bus.plot   = !CLIP || on_screen(sum_x, sum_y);
    end
  end

endmodule

// File: tb/tb_square_renderer.sv
// Self-checking bench for square_renderer: table vectors, hand-written corner sequences
// and random squares compared against a pixel-list reference model.
module tb_square_renderer;
  localparam int SIZE  = 4;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
`ifdef SQUARE_RENDERER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  square_renderer_if bus();

  square_renderer #(.SIZE(SIZE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct { int x; int y; int c; int p; } pix_t;
  typedef struct { int x0; int y0; int c; int er; int exp_plots; int exp_col; } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at a falling edge with the DUT idle; returns at the falling edge of the IDLE cycle after done.
  task automatic run_square(input int x0, input int y0, input int c, input int er,
                            input int hold, input int inject,
                            output int nplot, output int pcol);
    pix_t exp_q[$];
    pix_t e;
    int lx, ly, lc;
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < SIZE; k++) begin
        e.x = (x0 + k) % 256;
        e.y = (y0 + r) % 128;
        e.c = er ? 0 : c;
        e.p = (!CLIP || ((x0 + k) <= X_MAX && (y0 + r) <= Y_MAX)) ? 1 : 0;
        exp_q.push_back(e);
      end
    lx = 0; ly = 0; lc = 0;
    nplot = 0;
    pcol  = -1;
    bus.x_in      = 8'(x0);
    bus.y_in      = 7'(y0);
    bus.colour_in = 3'(c);
    bus.erase     = er[0];
    bus.go        = 1'b1;
    @(negedge clock);
    if (hold == 0) bus.go = 1'b0;
    for (int i = 0; i < SIZE * SIZE; i++) begin
      if (i == inject) begin
        bus.go   = 1'b1;
        bus.x_in = 8'd50;
        bus.y_in = 7'd50;
      end
      if (inject >= 0 && i == inject + 1) bus.go = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("pix%0d(%0d,%0d).plot", i, x0, y0), int'(bus.plot), e.p);
      chk($sformatf("pix%0d(%0d,%0d).x", i, x0, y0), int'(bus.x), e.x);
      chk($sformatf("pix%0d(%0d,%0d).y", i, x0, y0), int'(bus.y), e.y);
      chk($sformatf("pix%0d(%0d,%0d).colour", i, x0, y0), int'(bus.colour), e.c);
      chk($sformatf("pix%0d.busy", i), int'(bus.busy), 1);
      chk($sformatf("pix%0d.done", i), int'(bus.done), 0);
      if (bus.plot) begin
        nplot++;
        pcol = int'(bus.colour);
      end
      lx = e.x; ly = e.y; lc = e.c;
      if (i < SIZE * SIZE - 1) @(negedge clock);
    end
    @(negedge clock);
    chk("done_cycle.done", int'(bus.done), 1);
    chk("done_cycle.busy", int'(bus.busy), 1);
    chk("done_cycle.plot", int'(bus.plot), 0);
    chk("done_cycle.x_hold", int'(bus.x), lx);
    chk("done_cycle.y_hold", int'(bus.y), ly);
    chk("done_cycle.colour_hold", int'(bus.colour), lc);
    @(negedge clock);
    chk("idle_after.done", int'(bus.done), 0);
    chk("idle_after.busy", int'(bus.busy), 0);
    chk("idle_after.plot", int'(bus.plot), 0);
    chk("idle_after.x_hold", int'(bus.x), lx);
  endtask

  vec_t tbl[4];
  int   np, pc;

  initial begin
    tbl[0] = '{x0: 10,  y0: 20,  c: 4, er: 0, exp_plots: 16, exp_col: 4};
    tbl[1] = '{x0: 10,  y0: 20,  c: 7, er: 1, exp_plots: 16, exp_col: 0};
    tbl[2] = '{x0: 158, y0: 118, c: 5, er: 0, exp_plots: CLIP ? 4 : 16, exp_col: 5};
    tbl[3] = '{x0: 0,   y0: 0,   c: 2, er: 0, exp_plots: 16, exp_col: 2};

    bus.go = 1'b0; bus.erase = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;

    #1;
    chk("reset.plot", int'(bus.plot), 0);
    chk("reset.busy", int'(bus.busy), 0);
    chk("reset.done", int'(bus.done), 0);
    chk("reset.x", int'(bus.x), 0);
    chk("reset.y", int'(bus.y), 0);
    chk("reset.colour", int'(bus.colour), 0);
    bus.go = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("reset.go_ignored", int'(bus.busy), 0);
    bus.go = 1'b0;
    resetn = 1'b1;
    @(negedge clock);

    for (int t = 0; t < 4; t++) begin
      run_square(tbl[t].x0, tbl[t].y0, tbl[t].c, tbl[t].er, 0, -1, np, pc);
      chk($sformatf("tbl%0d.plots", t), np, tbl[t].exp_plots);
      chk($sformatf("tbl%0d.colour", t), pc, tbl[t].exp_col);
    end

    // Go pulsed at (50,50) in the 5th DRAW cycle must be dropped
    run_square(10, 20, 4, 0, 0, 4, np, pc);
    chk("dropped.plots", np, 16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("dropped.idle%0d.busy", i), int'(bus.busy), 0);
      chk($sformatf("dropped.idle%0d.done", i), int'(bus.done), 0);
    end

    // go held high: each square starts right after the IDLE cycle that follows done
    for (int s = 0; s < 3; s++) begin
      run_square(30 + 8 * s, 40 + s, s + 1, 0, 1, -1, np, pc);
      chk($sformatf("b2b%0d.plots", s), np, 16);
    end
    bus.go = 1'b0;
    @(negedge clock);
    chk("b2b.stop.busy", int'(bus.busy), 0);

    // Reset asserted during the 8th DRAW cycle
    bus.x_in = 8'd10; bus.y_in = 7'd20; bus.colour_in = 3'd6; bus.erase = 1'b0;
    bus.go = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    repeat (7) @(negedge clock);
    chk("midreset.pre.plot", int'(bus.plot), 1);
    chk("midreset.pre.x", int'(bus.x), 13);
    #1 resetn = 1'b0;
    #1;
    chk("midreset.plot", int'(bus.plot), 0);
    chk("midreset.busy", int'(bus.busy), 0);
    chk("midreset.x", int'(bus.x), 0);
    chk("midreset.y", int'(bus.y), 0);
    chk("midreset.colour", int'(bus.colour), 0);
    chk("midreset.done", int'(bus.done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("midreset.hold%0d.done", i), int'(bus.done), 0);
      chk($sformatf("midreset.hold%0d.plot", i), int'(bus.plot), 0);
    end
    resetn = 1'b1;
    @(negedge clock);
    chk("midreset.after.busy", int'(bus.busy), 0);
    run_square(10, 20, 6, 0, 0, -1, np, pc);
    chk("midreset.redraw.plots", np, 16);

    for (int r = 0; r < 20; r++) begin
      int rx, ry, rc, re, want;
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 127));
      rc = int'($urandom_range(0, 7));
      re = int'($urandom_range(0, 1));
      want = 0;
      for (int a = 0; a < SIZE; a++)
        for (int b = 0; b < SIZE; b++)
          if (!CLIP || ((rx + b) <= X_MAX && (ry + a) <= Y_MAX)) want++;
      run_square(rx, ry, rc, re, 0, -1, np, pc);
      chk($sformatf("rand%0d.plots", r), np, want);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
